cell_plane_writer: RTL

- Parametrised, command-driven successor to the terminal character path's SDRAM writer.
- Accepts decoded cell commands (put, rectangle fill, scroll up/down, set origin) over a valid/ready handshake.
- Turns them into single or burst SDRAM writes on a ring-buffered text page, and reprograms the video first-row register on scroll.
- Sits between the escape-code decoder and the SDRAM write port. Screen geometry and burst depth are parameters.

---
 rtl/cell_plane_writer_pkg.sv | 35 +++
 rtl/cell_plane_writer_if.sv | 39 +++
 rtl/cell_span_planner.sv | 39 +++
 rtl/cell_plane_writer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cell_plane_writer_pkg.sv
// Shared definitions for the cell plane writer.
// Contents: command op encodings, video register indices, the cell word
// layout and the writer FSM state type.
package cell_plane_writer_pkg;

    typedef enum logic [2:0] {
        CMD_NOP         = 3'd0,
        CMD_PUT         = 3'd1,
        CMD_FILL        = 3'd2,
        CMD_SCROLL_UP   = 3'd3,
        CMD_SCROLL_DOWN = 3'd4,
        CMD_SET_ORIGIN  = 3'd5
    } cmd_op_t;

    // Video controller register map
    localparam logic [3:0] VIDEO_NOP           = 4'd0;
    localparam logic [3:0] VIDEO_SET_FIRST_ROW = 4'd3;

    // One text cell as stored in SDRAM
    typedef struct packed {
        logic [7:0] bg;
        logic [7:0] fg;
        logic [7:0] attr;
        logic [7:0] glyph;
    } cell_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAN,
        ST_ISSUE,
        ST_WAIT,
        ST_NEXT
    } state_t;

endpackage

// File: rtl/cell_plane_writer_if.sv
// Bus bundle of the cell plane writer: command handshake from the escape
// decoder, SDRAM write port, video register port and status.
// slave  : the writer's view (takes commands, drives writes/registers).
// master : the decoder/SDRAM/video side.
interface cell_plane_writer_if;
    import cell_plane_writer_pkg::*;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [6:0]  cmd_x;
    logic [5:0]  cmd_y;
    logic [6:0]  cmd_w;
    logic [5:0]  cmd_h;
    logic [31:0] cmd_data;
    logic [22:0] wr_address;
    logic        wr_request;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;
    logic [8:0]  wr_burst_length;
    logic        wr_done;
    logic [3:0]  register_index;
    logic [22:0] register_value;
    logic [5:0]  first_row;
    logic        cmd_error;

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_data, wr_done,
        output cmd_ready, wr_address, wr_request, wr_data, wr_mask, wr_burst_length,
        output register_index, register_value, first_row, cmd_error
    );

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_data, wr_done,
        input  cmd_ready, wr_address, wr_request, wr_data, wr_mask, wr_burst_length,
        input  register_index, register_value, first_row, cmd_error
    );

endinterface

// File: rtl/cell_span_planner.sv
// Combinational span planner.
// Clips a rectangle to the page (i_x/i_w -> o_x_end, i_y/i_h -> o_y_end,
// both exclusive) and sizes the burst starting at i_col on a row whose span
// ends at i_col_end: o_len = min(remaining, MAX_BURST), o_next_col = i_col + o_len.
module cell_span_planner
    import cell_plane_writer_pkg::*;
#(
    parameter int COLUMNS   = 80,
    parameter int ROWS      = 51,
    parameter int MAX_BURST = 32
) (
    input  logic [6:0] i_x,
    input  logic [6:0] i_w,
    input  logic [5:0] i_y,
    input  logic [5:0] i_h,
    input  logic [7:0] i_col,
    input  logic [7:0] i_col_end,
    output logic [7:0] o_x_end,
    output logic [6:0] o_y_end,
    output logic [8:0] o_len,
    output logic [7:0] o_next_col
);
    logic [7:0] w_x_sum;
    logic [6:0] w_y_sum;
    logic [7:0] w_remaining;

    always_comb begin
        w_x_sum     = {1'b0, i_x} + {1'b0, i_w};
        o_x_end     = (w_x_sum > 8'(COLUMNS)) ? 8'(COLUMNS) : w_x_sum;
        w_y_sum     = {1'b0, i_y} + {1'b0, i_h};
        o_y_end     = (w_y_sum > 7'(ROWS)) ? 7'(ROWS) : w_y_sum;
        w_remaining = i_col_end - i_col;
        o_len       = ({1'b0, w_remaining} > 9'(MAX_BURST)) ? 9'(MAX_BURST)
                                                            : {1'b0, w_remaining};
        // A burst never exceeds the row remainder, so it fits in 8 bits here
        o_next_col  = i_col + o_len[7:0];
    end

endmodule

// File: rtl/cell_plane_writer.sv
// Cell plane writer: turns decoded cell commands into SDRAM single/burst
// writes on a ring-buffered text page and moves the video origin on scroll.
// Ports: clk, reset (sync, active-high); bus (slave modport) carrying the
// command handshake, SDRAM write port, video register pulse, first_row and
// cmd_error.
module cell_plane_writer
    import cell_plane_writer_pkg::*;
#(
    parameter int COLUMNS      = 80,
    parameter int ROWS         = 51,
    parameter int MAX_BURST    = 32,
    parameter int BASE_ADDRESS = 0
) (
    input  logic               clk,
    input  logic               reset,
    cell_plane_writer_if.slave bus
);
    state_t      r_state, w_state_nxt;
    logic [2:0]  r_op;
    logic [6:0]  r_cmd_x, r_cmd_w;
    logic [5:0]  r_cmd_y, r_cmd_h;
    logic [31:0] r_data;
    logic [5:0]  r_first_row;
    logic [3:0]  r_reg_index;
    logic [22:0] r_reg_value;
    logic [22:0] r_addr;
    logic [8:0]  r_len;
    logic [6:0]  r_row, r_row_end;
    logic [7:0]  r_col_start, r_col_end, r_next_col;

    logic        w_accept, w_bad, w_err, w_plan_load, w_next_load, w_origin_we;
    logic        w_wrap, w_span_done;
    logic [6:0]  w_n, w_raw;
    logic [5:0]  w_new_first, w_fr_eff, w_phys;
    logic [6:0]  w_ld_row, w_ld_row_end, w_sum;
    logic [7:0]  w_ld_col, w_ld_col_start, w_ld_col_end;
    logic [22:0] w_ld_addr;
    logic [7:0]  w_x_end, w_next_col;
    logic [6:0]  w_y_end;
    logic [8:0]  w_len;

    assign w_accept = (r_state == ST_IDLE) && bus.cmd_valid;

    // Out-of-page coordinates only matter for ops that address a cell or row
    assign w_bad = (r_op > CMD_SET_ORIGIN) ||
                   (((r_op == CMD_PUT) || (r_op == CMD_FILL) || (r_op == CMD_SET_ORIGIN)) &&
                    (({1'b0, r_cmd_x} >= 8'(COLUMNS)) || ({1'b0, r_cmd_y} >= 7'(ROWS))));

    // Scroll count clamped to the page; new origin via one conditional subtract
    always_comb begin
        w_n = ({1'b0, r_cmd_h} > 7'(ROWS)) ? 7'(ROWS) : {1'b0, r_cmd_h};
        if (r_op == CMD_SCROLL_UP) w_raw = {1'b0, r_first_row} + w_n;
        else                       w_raw = {1'b0, r_first_row} + 7'(ROWS) - w_n;
        w_new_first = 6'((w_raw >= 7'(ROWS)) ? w_raw - 7'(ROWS) : w_raw);
        if (r_op == CMD_SET_ORIGIN) w_new_first = r_cmd_y;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_plan_load = 1'b0;
        w_next_load = 1'b0;
        w_origin_we = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE:  if (bus.cmd_valid) w_state_nxt = ST_PLAN;
            ST_PLAN: begin
                w_state_nxt = ST_IDLE;
                if (w_bad) begin
                    w_err = 1'b1;
                end else begin
                    case (r_op)
                        CMD_PUT: begin
                            w_plan_load = 1'b1;
                            w_state_nxt = ST_ISSUE;
                        end
                        CMD_FILL: if ((r_cmd_w != '0) && (r_cmd_h != '0)) begin
                            w_plan_load = 1'b1;
                            w_state_nxt = ST_ISSUE;
                        end
                        CMD_SCROLL_UP, CMD_SCROLL_DOWN: if (w_n != '0) begin
                            w_origin_we = 1'b1;
                            w_plan_load = 1'b1;
                            w_state_nxt = ST_ISSUE;
                        end
                        CMD_SET_ORIGIN: w_origin_we = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (bus.wr_done) w_state_nxt = ST_NEXT;
            ST_NEXT: begin
                if (w_span_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_next_load = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Position of the chunk about to be loaded: the first chunk in PLAN,
    // otherwise the chunk following the one just completed.
    always_comb begin
        w_wrap         = (r_next_col == r_col_end);
        w_span_done    = w_wrap && ((r_row + 7'd1) == r_row_end);
        w_ld_row       = w_wrap ? r_row + 7'd1 : r_row;
        w_ld_col       = w_wrap ? r_col_start : r_next_col;
        w_ld_row_end   = r_row_end;
        w_ld_col_start = r_col_start;
        w_ld_col_end   = r_col_end;
        if (r_state == ST_PLAN) begin
            case (r_op)
                CMD_PUT: begin
                    w_ld_row     = {1'b0, r_cmd_y};
                    w_ld_row_end = {1'b0, r_cmd_y} + 7'd1;
                    w_ld_col     = {1'b0, r_cmd_x};
                    w_ld_col_end = {1'b0, r_cmd_x} + 8'd1;
                end
                CMD_FILL: begin
                    w_ld_row     = {1'b0, r_cmd_y};
                    w_ld_row_end = w_y_end;
                    w_ld_col     = {1'b0, r_cmd_x};
                    w_ld_col_end = w_x_end;
                end
                CMD_SCROLL_UP: begin
                    w_ld_row     = 7'(ROWS) - w_n;
                    w_ld_row_end = 7'(ROWS);
                    w_ld_col     = '0;
                    w_ld_col_end = 8'(COLUMNS);
                end
                CMD_SCROLL_DOWN: begin
                    w_ld_row     = '0;
                    w_ld_row_end = w_n;
                    w_ld_col     = '0;
                    w_ld_col_end = 8'(COLUMNS);
                end
                default: ;
            endcase
            w_ld_col_start = w_ld_col;
        end
        // Scroll fills must already use the new origin in PLAN
        w_fr_eff  = w_origin_we ? w_new_first : r_first_row;
        w_sum     = w_ld_row + {1'b0, w_fr_eff};
        w_phys    = 6'((w_sum >= 7'(ROWS)) ? w_sum - 7'(ROWS) : w_sum);
        w_ld_addr = 23'(BASE_ADDRESS) + {8'd0, w_phys, w_ld_col[6:0], 2'b00};
    end

    cell_span_planner #(
        .COLUMNS   (COLUMNS),
        .ROWS      (ROWS),
        .MAX_BURST (MAX_BURST)
    ) u_planner (
        .i_x        (r_cmd_x),
        .i_w        (r_cmd_w),
        .i_y        (r_cmd_y),
        .i_h        (r_cmd_h),
        .i_col      (w_ld_col),
        .i_col_end  (w_ld_col_end),
        .o_x_end    (w_x_end),
        .o_y_end    (w_y_end),
        .o_len      (w_len),
        .o_next_col (w_next_col)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_first_row <= '0;
            r_reg_index <= VIDEO_NOP;
            r_reg_value <= '0;
            r_addr      <= 23'(BASE_ADDRESS);
            r_len       <= 9'd1;
            r_data      <= '0;
        end else begin
            r_reg_index <= VIDEO_NOP;
            if (w_accept) begin
                r_op    <= bus.cmd_op;
                r_cmd_x <= bus.cmd_x;
                r_cmd_y <= bus.cmd_y;
                r_cmd_w <= bus.cmd_w;
                r_cmd_h <= bus.cmd_h;
                r_data  <= bus.cmd_data;
            end
            if (w_origin_we) begin
                r_first_row <= w_new_first;
                r_reg_index <= VIDEO_SET_FIRST_ROW;
                r_reg_value <= 23'(BASE_ADDRESS) + {8'd0, w_new_first, 7'd0, 2'b00};
            end
            if (w_plan_load || w_next_load) begin
                r_row       <= w_ld_row;
                r_row_end   <= w_ld_row_end;
                r_col_start <= w_ld_col_start;
                r_col_end   <= w_ld_col_end;
                r_next_col  <= w_next_col;
                r_addr      <= w_ld_addr;
                r_len       <= w_len;
            end
        end
    end

    assign bus.cmd_ready       = (r_state == ST_IDLE);
    assign bus.wr_request      = (r_state == ST_ISSUE);
    assign bus.wr_address      = r_addr;
    assign bus.wr_data         = r_data;
    assign bus.wr_mask         = 4'b1111;
    assign bus.wr_burst_length = r_len;
    assign bus.register_index  = r_reg_index;
    assign bus.register_value  = r_reg_value;
    assign bus.first_row       = r_first_row;
    assign bus.cmd_error       = w_err;

endmodule
